ls_queue: RTL

- In-order load/store queue directly downstream of the address unit.
- Accepts resolved {addr, op, rob_number, store value} each cycle and buffers up to DEPTH memory ops.
- Issues memory ops to the data-memory port strictly in program order; loads issue speculatively, stores only after ROB commit.
- Returns load results (sign/zero-extended) to the CDB/ROB; discards uncommitted entries on flush.

---
 rtl/ls_pkg.sv | 61 ++++++
 rtl/ls_queue_load_extend.sv | 30 +++
 rtl/ls_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ls_pkg.sv
// ls_pkg: shared definitions for the load/store queue.
// Holds the op-code map, access size encodings, the queue entry
// record, the issue FSM state type and small decode helpers used by
// both the queue and the load extender.
package ls_pkg;

  localparam int LS_XLEN  = 32;
  localparam int LS_ROB_W = 3;
  localparam int LS_OP_W  = 5;

  localparam logic [LS_OP_W-1:0] OP_LB  = 5'd0;
  localparam logic [LS_OP_W-1:0] OP_LH  = 5'd1;
  localparam logic [LS_OP_W-1:0] OP_LW  = 5'd2;
  localparam logic [LS_OP_W-1:0] OP_LBU = 5'd3;
  localparam logic [LS_OP_W-1:0] OP_LHU = 5'd4;
  localparam logic [LS_OP_W-1:0] OP_SB  = 5'd5;
  localparam logic [LS_OP_W-1:0] OP_SH  = 5'd6;
  localparam logic [LS_OP_W-1:0] OP_SW  = 5'd7;
  localparam logic [LS_OP_W-1:0] OP_NOP = 5'b11111;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // One buffered memory op; committed is only meaningful for stores.
  typedef struct packed {
    logic [LS_XLEN-1:0]  addr;
    logic [LS_XLEN-1:0]  data;
    logic [LS_OP_W-1:0]  op;
    logic [LS_ROB_W-1:0] rob;
    logic                committed;
  } entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  function automatic logic is_store(input logic [LS_OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [LS_OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SIZE_HALF;
      default:              op_size = SIZE_WORD;
    endcase
  endfunction

  // Keeps only the bytes a store of the given size writes; upper bits zero.
  function automatic logic [LS_XLEN-1:0] size_mask(input logic [LS_XLEN-1:0] data,
                                                   input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = {{(LS_XLEN-8){1'b0}}, data[7:0]};
      SIZE_HALF: size_mask = {{(LS_XLEN-16){1'b0}}, data[15:0]};
      default:   size_mask = data;
    endcase
  endfunction

endpackage

// File: rtl/ls_queue_load_extend.sv
// load_extend: turns right-aligned memory read data into the
// architectural load result for the given load op.
// Ports:
//   op        - load op code (LB/LH/LW/LBU/LHU)
//   rdata     - right-aligned read data from the data memory
//   res_value - sign/zero-extended result
module load_extend
  import ls_pkg::*;
#(
  parameter int XLEN = LS_XLEN,
  parameter int OP_W = LS_OP_W
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] res_value
);

  // Pure decode of the load flavour; anything unrecognised passes the word through.
  always_comb begin
    res_value = rdata;
    case (op)
      OP_LB:   res_value = {{(XLEN-8){rdata[7]}}, rdata[7:0]};
      OP_LH:   res_value = {{(XLEN-16){rdata[15]}}, rdata[15:0]};
      OP_LBU:  res_value = {{(XLEN-8){1'b0}}, rdata[7:0]};
      OP_LHU:  res_value = {{(XLEN-16){1'b0}}, rdata[15:0]};
      default: res_value = rdata;
    endcase
  end

endmodule

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue between the address unit and the
// data memory. Loads issue as soon as they reach the head; stores wait
// for their ROB commit. Load results are returned as a one-cycle pulse.
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   pause                    - blocks enqueue only
//   flush                    - drop every uncommitted entry
//   in_addr/op/rob/data      - op from the address unit (OP_NOP = none)
//   full                     - queue holds DEPTH entries
//   commit_valid/commit_rob  - ROB commits the store with this tag
//   mem_req/we/size/addr/wdata, mem_ready/rdata - data-memory port
//   res_valid/rob/value      - load result towards CDB/ROB
module ls_queue
  import ls_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = LS_XLEN,
  parameter int ROB_W = LS_ROB_W,
  parameter int OP_W  = LS_OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             flush,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [OP_W-1:0]  in_op,
  input  logic [ROB_W-1:0] in_rob,
  input  logic [XLEN-1:0]  in_data,
  output logic             full,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_rob,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_ready,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             res_valid,
  output logic [ROB_W-1:0] res_rob,
  output logic [XLEN-1:0]  res_value
);

  localparam int PW = $clog2(DEPTH);

  entry_t            q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  logic [PW:0]       cnt_next;
  logic [PW:0]       n_comm;
  state_t            state;
  logic              drop;
  logic              enq;
  logic              pop;
  logic              flush_pop;
  logic              enq_commit;
  logic [DEPTH-1:0]  commit_hit;
  entry_t            head_e;
  logic [XLEN-1:0]   ext_value;

  assign head_e     = q[head];
  assign full       = (count == (PW+1)'(DEPTH));
  assign enq        = (in_op != OP_NOP) && !pause && !full && !flush;
  // A dropped (flushed) load has already left the queue, so its completion pops nothing.
  assign pop        = (state == ST_REQ) && mem_ready && !drop;
  // Only a committed store can be popping under flush; its entry is in the kept prefix.
  assign flush_pop  = pop && mem_we;
  assign enq_commit = commit_valid && is_store(in_op) && (in_rob == commit_rob);

  load_extend #(.XLEN(XLEN), .OP_W(OP_W)) u_load_extend (
    .op        (head_e.op),
    .rdata     (mem_rdata),
    .res_value (ext_value)
  );

  // Which live store entries the ROB is committing this cycle.
  always_comb begin
    logic [PW-1:0] offs;
    offs       = '0;
    commit_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head;
      commit_hit[i] = commit_valid && ({1'b0, offs} < count) &&
                      is_store(q[i].op) && (q[i].rob == commit_rob);
    end
  end

  // Length of the committed run starting at head, including this cycle's commit;
  // this is what survives a flush.
  always_comb begin
    logic          stop;
    logic [PW-1:0] idx;
    n_comm = '0;
    stop   = 1'b0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (!stop && ((PW+1)'(i) < count) && (q[idx].committed || commit_hit[idx]))
        n_comm = n_comm + (PW+1)'(1);
      else
        stop = 1'b1;
    end
  end

  always_comb begin
    cnt_next = count;
    if (enq && !pop)
      cnt_next = count + (PW+1)'(1);
    else if (!enq && pop)
      cnt_next = count - (PW+1)'(1);
  end

  // Head/tail/count bookkeeping; a flush truncates the queue to its committed prefix.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= head + PW'(flush_pop);
      tail  <= head + n_comm[PW-1:0];
      count <= n_comm - (PW+1)'(flush_pop);
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= cnt_next;
    end
  end

  // Entry storage; the newly written entry can pick up a commit in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) q[i].committed <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (commit_hit[i]) q[i].committed <= 1'b1;
      if (enq) begin
        q[tail].addr      <= in_addr;
        q[tail].data      <= in_data;
        q[tail].op        <= in_op;
        q[tail].rob       <= in_rob;
        q[tail].committed <= enq_commit;
      end
    end
  end

  // Issue FSM: one outstanding request at a time, all request fields registered
  // at issue and held until mem_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      res_valid <= 1'b0;
      res_rob   <= '0;
      res_value <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Issue is held off in a flush cycle; the surviving head issues next cycle.
          if (!flush && (count != '0) && (!is_store(head_e.op) || head_e.committed)) begin
            state     <= ST_REQ;
            mem_req   <= 1'b1;
            mem_we    <= is_store(head_e.op);
            mem_size  <= op_size(head_e.op);
            mem_addr  <= head_e.addr;
            mem_wdata <= is_store(head_e.op) ? size_mask(head_e.data, op_size(head_e.op)) : '0;
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            state     <= ST_IDLE;
            drop      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (!mem_we && !drop && !flush) begin
              res_valid <= 1'b1;
              res_rob   <= head_e.rob;
              res_value <= ext_value;
            end
          end else if (flush && !mem_we) begin
            // The load must still finish on the bus, but its result is squashed.
            drop <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
